// File: rtl/reg_port_sequencer.sv
// Client-side sequencer for a 32x32 register file with a shared read/write port A.
// Arbitrates writeback against operand fetch, absorbs the read latency and bypasses in-flight writes.
module reg_port_sequencer #(
   parameter int WB_BURST = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rd_req_valid,
   output logic        rd_req_ready,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   output logic        op_valid,
   input  logic        op_ready,
   output logic [31:0] op_a,
   output logic [31:0] op_b,
   input  logic        wb_valid,
   output logic        wb_ready,
   input  logic [4:0]  wb_addr,
   input  logic [31:0] wb_data,
   output logic [4:0]  rf_address_a,
   output logic [4:0]  rf_address_b,
   output logic [31:0] rf_in_a,
   output logic        rf_wren_a,
   input  logic [31:0] rf_out_a,
   input  logic [31:0] rf_out_b
);

   localparam int CW = $clog2(WB_BURST + 1);

   typedef enum logic [1:0] {IDLE, CAPTURE, HOLD} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] burst_cnt;
   logic [4:0]    rs1_q, rs2_q;
   logic          rd_fire, wb_fire, op_done, bypass_a, bypass_b;

   // NOTE: every output of this block is given a default first, so no path can infer a latch.
   always_comb begin
      state_nxt    = state;
      rd_req_ready = 1'b0;
      rf_address_a = '0;
      rf_address_b = '0;
      rf_in_a      = '0;
      rf_wren_a    = 1'b0;

      case (state)
         IDLE: begin
            rd_req_ready = !wb_valid || (burst_cnt == CW'(WB_BURST));
            if (rd_req_valid && rd_req_ready) state_nxt = CAPTURE;
         end
         CAPTURE: state_nxt = HOLD;
         HOLD:    if (op_valid && op_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase

      rd_fire  = rd_req_valid && rd_req_ready;
      wb_ready = !rd_fire;
      wb_fire  = wb_valid && wb_ready;
      op_done  = (state == HOLD) && op_valid && op_ready;

      // Port A carries the read address on issue, otherwise the writeback; x0 writes are dropped here.
      if (rd_fire) begin
         rf_address_a = rs1;
         rf_address_b = rs2;
      end else if (wb_fire) begin
         rf_address_a = wb_addr;
         rf_in_a      = wb_data;
         rf_wren_a    = (wb_addr != 5'd0);
      end

      bypass_a = wb_fire && (rs1_q != 5'd0) && (wb_addr == rs1_q);
      bypass_b = wb_fire && (rs2_q != 5'd0) && (wb_addr == rs2_q);
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         op_valid  <= 1'b0;
         op_a      <= '0;
         op_b      <= '0;
         burst_cnt <= '0;
         rs1_q     <= '0;
         rs2_q     <= '0;
      end else begin
         state <= state_nxt;

         // Counts writeback grants that starve a waiting read; saturates at the issue threshold.
         if (rd_fire || !rd_req_valid)
            burst_cnt <= '0;
         else if ((state == IDLE) && wb_fire && (burst_cnt != CW'(WB_BURST)))
            burst_cnt <= burst_cnt + 1'b1;

         if (rd_fire) begin
            rs1_q <= rs1;
            rs2_q <= rs2;
         end

         case (state)
            CAPTURE: begin
               op_a     <= (rs1_q == 5'd0) ? '0 : (bypass_a ? wb_data : rf_out_a);
               op_b     <= (rs2_q == 5'd0) ? '0 : (bypass_b ? wb_data : rf_out_b);
               op_valid <= 1'b1;
            end
            HOLD: begin
               if (op_done) begin
                  op_valid <= 1'b0;
               end else begin
                  if (bypass_a) op_a <= wb_data;
                  if (bypass_b) op_b <= wb_data;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
